mac_operand_sequencer: RTL and testbench

//  Upstream feeder for the 8x8->16 multiply-accumulate stage. Buffers operand pairs in a small FIFO.

---
 rtl/mac_operand_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: operand FIFO feeding an 8x8->16 MAC, clear/feed/drain sequencing.
// Define MACSEQ_OVF_EN to add the sticky 16-bit wrap flag on res_ovf.
module mac_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_opa,
  input  logic [7:0]       in_opb,
  output logic [7:0]       mac_opa,
  output logic [7:0]       mac_opb,
  output logic             mac_clr,
  input  logic [15:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data
`ifdef MACSEQ_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [15:0]      mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [15:0]      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [LEN_W-1:0] rem;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == FEED) && !empty;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  // Held high through reset so the MAC starts from a cleared accumulator.
  assign mac_clr   = !clr_n || (state == CLEAR);
  assign mac_opa   = pop ? head[15:8] : 8'd0;
  assign mac_opb   = pop ? head[7:0]  : 8'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {in_opa, in_opb};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = (rem != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (pop && (rem == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      rem      <= '0;
      res_data <= '0;
    end else begin
      state <= state_d;
      if ((state == IDLE) && start) begin
        rem <= len;
      end else if (pop) begin
        rem <= rem - 1'b1;
      end
      // Last accumulate landed at the edge that entered DRAIN.
      if (state == DRAIN) begin
        res_data <= mac_out;
      end
    end
  end

`ifdef MACSEQ_OVF_EN
  logic [15:0] prev;
  logic        pop_d;
  logic        ovf;
  logic        track;

  assign track = (state == SETTLE) || (state == FEED) ||
                 (state == DRAIN);

  // A pop's sum is visible one cycle later; prev then holds the pre-pop value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev  <= '0;
      pop_d <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      pop_d <= pop;
      if (track) begin
        prev <= mac_out;
      end
      if (state == CLEAR) begin
        ovf <= 1'b0;
      end else if (pop_d && (mac_out < prev)) begin
        ovf <= 1'b1;
      end
    end
  end

  assign res_ovf = res_valid && ovf;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: ideal MAC model plus queue-based reference.
// Covers MACSEQ_OVF_EN when that macro is defined for the build.
module tb_mac_operand_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_opa = '0;
  logic [7:0]       in_opb = '0;
  logic             res_ready = 1'b0;
  logic [15:0]      mac_out = '0;
  logic             busy;
  logic             in_ready;
  logic [7:0]       mac_opa;
  logic [7:0]       mac_opb;
  logic             mac_clr;
  logic             res_valid;
  logic [15:0]      res_data;
`ifdef MACSEQ_OVF_EN
  logic             res_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int s_edge = 0;
  logic [15:0] q[$];

  mac_operand_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .len(len),
    .busy(busy),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opa(in_opa),
    .in_opb(in_opb),
    .mac_opa(mac_opa),
    .mac_opb(mac_opb),
    .mac_clr(mac_clr),
    .mac_out(mac_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
`ifdef MACSEQ_OVF_EN
    ,
    .res_ovf(res_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Ideal MAC and the record of every accepted operand pair.
  always @(posedge clk) begin
    ecount++;
    mac_out <= mac_clr ? 16'd0 :
               mac_out + 16'(mac_opa) * 16'(mac_opb);
    if (clr_n && in_valid && in_ready) q.push_back({in_opa, in_opb});
  end

  always @(negedge clr_n) q.delete();

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_opa = a;
    in_opb = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    s_edge = ecount;
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (!res_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    lat = ecount - s_edge;
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL result_timeout: res_valid=%0b want 1", res_valid);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic model_take(input int l, output logic [15:0] r,
                            output logic o);
    logic [15:0] p;
    int s;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (q.size() == 0) break;
      p = q.pop_front();
      s = int'(r) + int'(p[15:8]) * int'(p[7:0]);
      if (s > 65535) o = 1'b1;
      r = 16'(s);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #2;
    checks++;
    if ({busy, res_valid, in_ready, mac_clr} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl: busy,valid,ready,clr=%b want 0011",
               {busy, res_valid, in_ready, mac_clr});
    end
    checks++;
    if ({mac_opa, mac_opb, res_data} !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: opa=%0d opb=%0d res=%0d want 0",
               mac_opa, mac_opb, res_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mac_clr !== 1'b0) begin
      errors++;
      $display("FAIL idle_clr: mac_clr=%0b want 0", mac_clr);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd1, 8'd10);
    push(8'd2, 8'd10);
    push(8'd3, 8'd10);
    checks++;
    if (mac_opa !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ops: opa=%0d busy=%0b want 0 0", mac_opa, busy);
    end
    do_start(3);
    checks++;
    if (mac_clr !== 1'b1 || mac_opa !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_state: clr=%0b opa=%0d busy=%0b want 1 0 1",
               mac_clr, mac_opa, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (mac_clr !== 1'b0 || mac_opa !== 8'd0 || mac_opb !== 8'd0) begin
      errors++;
      $display("FAIL settle_state: clr=%0b opa=%0d opb=%0d want 0 0 0",
               mac_clr, mac_opa, mac_opb);
    end
    wait_valid(lat);
    model_take(3, r, o);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 6", lat);
    end
    checks++;
    if (res_data !== r || res_data !== 16'd60) begin
      errors++;
      $display("FAIL basic_data: got %0d want %0d", res_data, r);
    end
    handshake();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: busy=%0b valid=%0b want 0 0",
               busy, res_valid);
    end
  endtask

  task automatic test_starve();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd4, 8'd5);
    do_start(2);
    repeat (4) @(posedge clk);
    #1;
    push(8'd6, 8'd7);
    wait_valid(lat);
    model_take(2, r, o);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL starve_latency: got %0d want 7", lat);
    end
    checks++;
    if (res_data !== r || res_data !== 16'd62) begin
      errors++;
      $display("FAIL starve_data: got %0d want %0d", res_data, r);
    end
    handshake();
  endtask

  task automatic test_len0();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd9, 8'd9);
    do_start(0);
    wait_valid(lat);
    model_take(0, r, o);
    checks++;
    if (lat !== 3 || res_data !== 16'd0) begin
      errors++;
      $display("FAIL len0: lat=%0d res=%0d want 3 0", lat, res_data);
    end
    handshake();
    do_start(1);
    wait_valid(lat);
    model_take(1, r, o);
    checks++;
    if (lat !== 4 || res_data !== r) begin
      errors++;
      $display("FAIL len0_keep: lat=%0d res=%0d want 4 %0d",
               lat, res_data, r);
    end
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd2, 8'd3);
    do_start(1);
    wait_valid(lat);
    model_take(1, r, o);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i >= 3 && i < 8);
      in_opa = 8'(i);
      in_opb = 8'(i + 1);
      start = (i == 2);
      len = LEN_W'(1);
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== r) begin
        errors++;
        $display("FAIL hold_%0d: valid=%0b res=%0d want 1 %0d",
                 i, res_valid, res_data, r);
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || q.size() != DEPTH) begin
      errors++;
      $display("FAIL hold_full: in_ready=%0b stored=%0d want 0 %0d",
               in_ready, q.size(), DEPTH);
    end
    start = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_start_ignored: busy=%0b want 0", busy);
    end
    do_start(4);
    wait_valid(lat);
    model_take(4, r, o);
    checks++;
    if (lat !== 7 || res_data !== r || res_data !== 16'd104) begin
      errors++;
      $display("FAIL hold_next: lat=%0d res=%0d want 7 %0d",
               lat, res_data, r);
    end
    handshake();
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd11, 8'd12);
    push(8'd13, 8'd14);
    do_start(5);
    clr_n = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, in_ready, mac_clr} !== 4'b0011) begin
      errors++;
      $display("FAIL abort: busy,valid,ready,clr=%b want 0011",
               {busy, res_valid, in_ready, mac_clr});
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    push(8'd3, 8'd3);
    do_start(1);
    wait_valid(lat);
    model_take(1, r, o);
    checks++;
    if (res_data !== r || res_data !== 16'd9) begin
      errors++;
      $display("FAIL abort_flush: got %0d want %0d", res_data, r);
    end
    handshake();
  endtask

`ifdef MACSEQ_OVF_EN
  task automatic test_ovf();
    int lat;
    logic [15:0] r;
    logic o;
    push(8'd255, 8'd255);
    push(8'd255, 8'd255);
    do_start(2);
    wait_valid(lat);
    model_take(2, r, o);
    checks++;
    if (res_data !== 16'd64514 || res_ovf !== 1'b1 || !o) begin
      errors++;
      $display("FAIL ovf_set: res=%0d ovf=%0b want 64514 1",
               res_data, res_ovf);
    end
    handshake();
    checks++;
    if (res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle: ovf=%0b want 0", res_ovf);
    end
    push(8'd1, 8'd1);
    do_start(1);
    wait_valid(lat);
    model_take(1, r, o);
    checks++;
    if (res_data !== 16'd1 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: res=%0d ovf=%0b want 1 0",
               res_data, res_ovf);
    end
    handshake();
  endtask
`endif

  task automatic test_random();
    int lat;
    int l;
    int pre;
    int need;
    logic [15:0] r;
    logic o;
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(0, 7);
      pre = $urandom_range(0, DEPTH - q.size());
      for (int k = 0; k < pre; k++) begin
        push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      need = (l > q.size()) ? l - q.size() : 0;
      do_start(l);
      fork
        begin
          for (int k = 0; k < need; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          end
        end
        begin
          wait_valid(lat);
        end
      join
      model_take(l, r, o);
      checks++;
      if (res_data !== r) begin
        errors++;
        $display("FAIL rand_data_%0d: got %0d want %0d", it, res_data, r);
      end
      if (need == 0) begin
        checks++;
        if (lat !== l + 3) begin
          errors++;
          $display("FAIL rand_lat_%0d: got %0d want %0d", it, lat, l + 3);
        end
      end
`ifdef MACSEQ_OVF_EN
      checks++;
      if (res_ovf !== o) begin
        errors++;
        $display("FAIL rand_ovf_%0d: got %0b want %0b", it, res_ovf, o);
      end
`endif
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_len0();
    test_hold();
    test_abort();
`ifdef MACSEQ_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
